// File: rtl/wb_arbiter_pkg.sv
// Writeback shared definitions, also used by the register file.
//   WB_ADDR_WIDTH / WB_DATA_WIDTH : default register index / data widths
//   ZERO_REG                      : hardwired-zero register index; writes to it are dropped
//   wb_req                        : one writeback request {rd, data} at the default widths
package wb_arbiter_pkg;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int ZERO_REG      = 0;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for LSU writeback results.
//   clk, rst                 : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_push_rd/data   : enqueue one entry (caller guarantees not full)
//   i_pop                    : drop the head entry (caller guarantees not empty)
//   o_count                  : occupied entries, 0..DEPTH
//   o_head_rd/data           : head entry contents
//   o_ent_rd, o_ent_vld      : every slot's rd and whether it is occupied (hazard compare)
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int AW    = WB_ADDR_WIDTH,
  parameter int DW    = WB_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [AW-1:0]               i_push_rd,
  input  logic [DW-1:0]               i_push_data,
  input  logic                        i_pop,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [AW-1:0]               o_head_rd,
  output logic [DW-1:0]               o_head_data,
  output logic [DEPTH-1:0][AW-1:0]    o_ent_rd,
  output logic [DEPTH-1:0]            o_ent_vld
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;

  // Payload needs no reset: occupancy is derived from pointers/count only.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rd[r_wptr]   <= i_push_rd;
      r_data[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head_rd   = r_rd[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_ent_rd    = r_rd;

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the count; stale slots outside that window are ignored.
  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] w_off;
    assign w_off        = PW'(g) - r_rptr;
    assign o_ent_vld[g] = ({1'b0, w_off} < r_count);
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port.
//   clk, rst                       : clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data      : single-cycle ALU result, never back-pressured
//   alu_stall                      : registered request to hold off ALU results
//   lsu_valid/lsu_ready/rd/data    : LSU result handshake into the buffer FIFO
//   rf_wen/rf_waddr/rf_wdata       : registered register-file write
//   q_addrN/q_pendingN             : combinational pending-write query for decode
// ALU results win; the FIFO head drains whenever the ALU does not write.
// A starve counter raises alu_stall when the FIFO head is blocked too long.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  output logic                  q_pending1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_pending2
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] RD_ZERO = ADDR_WIDTH'(ZERO_REG);

  logic [CW-1:0]                    w_count;
  logic [ADDR_WIDTH-1:0]            w_head_rd;
  logic [DATA_WIDTH-1:0]            w_head_data;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] w_ent_rd;
  logic [DEPTH-1:0]                 w_ent_vld;
  logic                             w_nempty;
  logic                             w_alu_win;
  logic                             w_pop;
  logic                             w_push;
  logic                             w_hit1;
  logic                             w_hit2;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_stall;
  logic [SW-1:0]         r_starve;

  assign w_nempty  = (w_count != '0);
  assign lsu_ready = (w_count < CW'(DEPTH));
  // Writes to the zero register are dropped, so they neither win nor block.
  assign w_alu_win = alu_valid && (alu_rd != RD_ZERO);
  assign w_pop     = !w_alu_win && w_nempty;
  // An rd=0 LSU result completes the handshake but is not buffered.
  assign w_push    = lsu_valid && lsu_ready && (lsu_rd != RD_ZERO);

  wb_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_rd   (lsu_rd),
    .i_push_data (lsu_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_ent_rd    (w_ent_rd),
    .o_ent_vld   (w_ent_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_stall  <= 1'b0;
      r_starve <= '0;
    end else begin
      if (w_alu_win) begin
        r_wen   <= 1'b1;
        r_waddr <= alu_rd;
        r_wdata <= alu_data;
      end else if (w_pop) begin
        r_wen   <= 1'b1;
        r_waddr <= w_head_rd;
        r_wdata <= w_head_data;
      end else begin
        r_wen   <= 1'b0;
      end

      // Counter only moves while the head is blocked by the ALU; it stays
      // saturated if the ALU keeps writing through an asserted stall.
      if (w_pop || !w_nempty)
        r_starve <= '0;
      else if (w_alu_win && (r_starve != SW'(STARVE_LIMIT)))
        r_starve <= r_starve + 1'b1;

      r_stall <= (r_starve == SW'(STARVE_LIMIT)) && !w_pop;
    end
  end

  assign rf_wen    = r_wen;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign alu_stall = r_stall;

  // Pending = buffered in an occupied slot, or being written by rf_* right now.
  always_comb begin
    w_hit1 = r_wen && (r_waddr == q_addr1);
    w_hit2 = r_wen && (r_waddr == q_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i] == q_addr1)) w_hit1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i] == q_addr2)) w_hit2 = 1'b1;
    end
  end

  assign q_pending1 = (q_addr1 != RD_ZERO) && w_hit1;
  assign q_pending2 = (q_addr2 != RD_ZERO) && w_hit2;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int AW    = WB_ADDR_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, lsu_valid;
  logic [AW-1:0] alu_rd, lsu_rd, q_addr1, q_addr2;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_stall, lsu_ready, rf_wen, q_pending1, q_pending2;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_pending1(q_pending1), .q_addr2(q_addr2), .q_pending2(q_pending2)
  );

  // Reference model: a queue of pending LSU results plus the visible write port.
  wb_req         m_q[$];
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_blocked;
  bit            m_stall;

  function automatic bit m_pending(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_wen && m_waddr == a) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit    alu_win, pop, push, was_empty;
    wb_req h;
    if (rst) begin
      m_q.delete();
      m_wen = 0; m_waddr = '0; m_wdata = '0; m_blocked = 0; m_stall = 0;
      return;
    end
    was_empty = (m_q.size() == 0);
    alu_win   = alu_valid && alu_rd != 0;
    pop       = !alu_win && !was_empty;
    push      = lsu_valid && (m_q.size() < DEPTH) && lsu_rd != 0;
    m_stall   = (m_blocked == LIMIT) && !pop;
    if (pop || was_empty) m_blocked = 0;
    else if (alu_win && m_blocked < LIMIT) m_blocked++;
    if (alu_win) begin
      m_wen = 1; m_waddr = alu_rd; m_wdata = alu_data;
    end else if (pop) begin
      h = m_q.pop_front();
      m_wen = 1; m_waddr = h.rd; m_wdata = h.data;
    end else begin
      m_wen = 0;
    end
    if (push) begin
      h.rd = lsu_rd; h.data = lsu_data;
      m_q.push_back(h);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 0; lsu_valid = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1; alu_valid = 0; lsu_valid = 0; alu_rd = '0; lsu_rd = '0;
    alu_data = '0; lsu_data = '0; q_addr1 = '0; q_addr2 = '0;
    step(); step();
    rst = 0;
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      failures++;
      $display("FAIL reset_rf: wen=%b waddr=%0d wdata=%h expected 0/0/0", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (alu_stall !== 1'b0 || lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctl: stall=%b ready=%b expected 0/1", alu_stall, lsu_ready);
    end
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL alu_write: wen=%b waddr=%0d wdata=%h expected 1/3/deadbeef", rf_wen, rf_waddr, rf_wdata);
    end
    step();
    checks++;
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd3) begin
      failures++;
      $display("FAIL alu_idle: wen=%b waddr=%0d expected 0/3 (held)", rf_wen, rf_waddr);
    end
  endtask

  task automatic test_lsu_only();
    q_addr1 = 5'd7;
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsu_ready_empty: got %b expected 1", lsu_ready);
    end
    step();
    lsu_valid = 0;
    checks++;
    if (rf_wen !== 1'b0 || q_pending1 !== 1'b1) begin
      failures++;
      $display("FAIL lsu_edge1: wen=%b pending1=%b expected 0/1", rf_wen, q_pending1);
    end
    step();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234 || q_pending1 !== 1'b1) begin
      failures++;
      $display("FAIL lsu_edge2: wen=%b waddr=%0d wdata=%h pending1=%b expected 1/7/1234/1",
               rf_wen, rf_waddr, rf_wdata, q_pending1);
    end
    step();
    checks++;
    if (rf_wen !== 1'b0 || q_pending1 !== 1'b0) begin
      failures++;
      $display("FAIL lsu_edge3: wen=%b pending1=%b expected 0/0", rf_wen, q_pending1);
    end
  endtask

  task automatic test_fill_backpressure();
    logic [AW-1:0] exp_rd[5];
    bit hs;
    exp_rd = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = AW'(8 + i); lsu_data = DW'(32'h100 + i);
      step();
    end
    checks++;
    if (lsu_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_ready: got %b expected 0", lsu_ready);
    end
    lsu_rd = 5'd12; lsu_data = 32'h5555;
    step(); step();
    checks++;
    if (lsu_ready !== 1'b0 || rf_waddr !== 5'd1) begin
      failures++;
      $display("FAIL fill_hold: ready=%b waddr=%0d expected 0/1", lsu_ready, rf_waddr);
    end
    alu_valid = 0;
    for (int i = 0; i < 5; i++) begin
      hs = lsu_valid && lsu_ready;
      step();
      if (hs) lsu_valid = 0;
      checks++;
      if (rf_wen !== 1'b1 || rf_waddr !== exp_rd[i]) begin
        failures++;
        $display("FAIL drain_order[%0d]: wen=%b waddr=%0d expected 1/%0d", i, rf_wen, rf_waddr, exp_rd[i]);
      end
    end
    checks++;
    if (rf_wdata !== 32'h5555) begin
      failures++;
      $display("FAIL drain_fifth_data: got %h expected 5555", rf_wdata);
    end
    lsu_valid = 0;
    step();
    checks++;
    if (rf_wen !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: wen=%b expected 0", rf_wen);
    end
  endtask

  task automatic test_starvation();
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd20; lsu_data = 32'h2020;
    step();
    lsu_valid = 0;
    for (int i = 0; i < LIMIT; i++) step();
    checks++;
    if (alu_stall !== 1'b0) begin
      failures++;
      $display("FAIL starve_early: stall=%b expected 0", alu_stall);
    end
    step();
    checks++;
    if (alu_stall !== 1'b1) begin
      failures++;
      $display("FAIL starve_assert: stall=%b expected 1", alu_stall);
    end
    alu_valid = 0;
    step();
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd20 || alu_stall !== 1'b0) begin
      failures++;
      $display("FAIL starve_release: wen=%b waddr=%0d stall=%b expected 1/20/0", rf_wen, rf_waddr, alu_stall);
    end
  endtask

  task automatic test_x0();
    lsu_valid = 1; lsu_rd = 5'd5; lsu_data = 32'h55;
    step();
    lsu_valid = 0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    q_addr1 = 5'd5; q_addr2 = 5'd0;
    step();
    alu_valid = 0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin
      failures++;
      $display("FAIL x0_alu_drain: wen=%b waddr=%0d wdata=%h expected 1/5/55", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    if (q_pending1 !== 1'b1 || q_pending2 !== 1'b0) begin
      failures++;
      $display("FAIL x0_query: p1=%b p2=%b expected 1/0", q_pending1, q_pending2);
    end
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h77;
    checks++;
    if (lsu_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_lsu_ready: got %b expected 1", lsu_ready);
    end
    step();
    lsu_valid = 0;
    step();
    checks++;
    if (rf_wen !== 1'b0 || lsu_ready !== 1'b1 || q_pending2 !== 1'b0) begin
      failures++;
      $display("FAIL x0_lsu_dropped: wen=%b ready=%b p2=%b expected 0/1/0", rf_wen, lsu_ready, q_pending2);
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = AW'(13 + i); lsu_data = DW'(i);
      step();
    end
    lsu_valid = 0; alu_valid = 0;
    q_addr1 = 5'd14; q_addr2 = 5'd13;
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (rf_wen !== 1'b0 || lsu_ready !== 1'b1 || q_pending1 !== 1'b0 || q_pending2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: wen=%b ready=%b p1=%b p2=%b expected 0/1/0/0",
               rf_wen, lsu_ready, q_pending1, q_pending2);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rf_wen !== 1'b0) begin
        failures++;
        $display("FAIL reset_stale[%0d]: wen=%b waddr=%0d expected wen 0", i, rf_wen, rf_waddr);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      alu_valid = ($urandom_range(0, 99) < 55) && (!alu_stall || $urandom_range(0, 15) == 0);
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 50);
      lsu_rd    = AW'($urandom_range(0, 7));
      lsu_data  = $urandom;
      q_addr1   = AW'($urandom_range(0, 7));
      q_addr2   = AW'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 299) == 0);
      step();
      rst = 0;
      checks++;
      if (rf_wen !== m_wen || (m_wen && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        failures++;
        $display("FAIL rand_rf[%0d]: wen=%b waddr=%0d wdata=%h expected %b/%0d/%h",
                 n, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
      end
      checks++;
      if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        failures++;
        $display("FAIL rand_hold[%0d]: waddr=%0d wdata=%h expected %0d/%h", n, rf_waddr, rf_wdata, m_waddr, m_wdata);
      end
      checks++;
      if (alu_stall !== m_stall || lsu_ready !== (m_q.size() < DEPTH)) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: stall=%b ready=%b expected %b/%b",
                 n, alu_stall, lsu_ready, m_stall, m_q.size() < DEPTH);
      end
      checks++;
      if (q_pending1 !== m_pending(q_addr1) || q_pending2 !== m_pending(q_addr2)) begin
        failures++;
        $display("FAIL rand_pending[%0d]: p1=%b p2=%b expected %b/%b (q1=%0d q2=%0d)",
                 n, q_pending1, q_pending2, m_pending(q_addr1), m_pending(q_addr2), q_addr1, q_addr2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    idle(2);
    test_lsu_only();
    idle(2);
    test_fill_backpressure();
    idle(2);
    test_starvation();
    idle(2);
    test_x0();
    idle(2);
    test_reset_mid();
    idle(2);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback arbiter directly upstream of the register file's single write port. Merges two result sources into one registered write per cycle:
- single-cycle ALU results, never back-pressured;
- multi-cycle LSU results, valid/ready handshake, buffered in a small FIFO.

It also reports pending writes so the decode stage can detect read-after-write hazards against buffered results.

Parameters:
ADDR_WIDTH, 5, register index width (matches register file)
DATA_WIDTH, 32, register data width
DEPTH, 4, LSU result FIFO entries; power of 2, >= 2
STARVE_LIMIT, 8, consecutive cycles FIFO head may be blocked by ALU before alu_stall asserts; >= 1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
alu_stall  output  1  registered; upstream must not present alu_valid this cycle
lsu_valid  input  1  LSU result offered
lsu_ready  output  1  FIFO accepts this cycle
lsu_rd  input  ADDR_WIDTH  LSU destination register
lsu_data  input  DATA_WIDTH  LSU result
rf_wen  output  1  registered write enable to register file
rf_waddr  output  ADDR_WIDTH  registered write address
rf_wdata  output  DATA_WIDTH  registered write data
q_addr1  input  ADDR_WIDTH  hazard query address 1
q_pending1  output  1  combinational: q_addr1 has a pending write
q_addr2  input  ADDR_WIDTH  hazard query address 2
q_pending2  output  1  combinational: q_addr2 has a pending write

Behaviour:
- Reset (sync, rst=1 at a clock edge) sets the following; it takes priority over all in-flight activity, and any buffered LSU results are discarded:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, alu_stall=0;
  - FIFO count=0, read/write pointers=0, starve counter=0.
- lsu_ready = (count < DEPTH). It depends only on registered count, never on the pop in the same cycle.
- Push: lsu_valid && lsu_ready.
  - lsu_rd != 0: enqueue {rd, data}.
  - lsu_rd == 0: handshake completes but nothing is enqueued.
- Selection each cycle; the chosen write appears on rf_* at the next edge (1-cycle latency):
  1. alu_valid && alu_rd != 0: rf_wen<=1, rf_waddr<=alu_rd, rf_wdata<=alu_data. No pop.
  2. Otherwise, count > 0: pop the head; rf_wen<=1 with the head's rd/data.
  3. Otherwise: rf_wen<=0. rf_waddr and rf_wdata hold their previous values.
- An ALU write to rd 0 never drives rf_wen and does not block the FIFO drain.
- Push and pop in the same cycle: count unchanged; the pointers of both advance.
- A push into an empty FIFO is not bypassed. Minimum LSU latency is 2 edges from handshake to rf_wen.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Starvation control:
  - Starve counter increments when count>0 and rule 1 wins; it saturates at STARVE_LIMIT.
  - It clears on any pop or when count==0.
  - alu_stall <= (counter == STARVE_LIMIT) && no pop this cycle.
  - If alu_valid is asserted while alu_stall=1 (protocol violation), the ALU still wins and the counter stays saturated. No data is lost.
- q_pendingN = (q_addrN != 0) && (a valid FIFO entry has rd == q_addrN, OR rf_wen && rf_waddr == q_addrN).
  - Only occupied slots are compared; stale slots are ignored.
- Ordering: the FIFO preserves LSU order. ALU-vs-LSU ordering to the same rd is the pipeline's responsibility, enforced via q_pending.

Decomposition:
- Shared package (the one the register file uses): ADDR_WIDTH/DATA_WIDTH defaults, ZERO_REG constant, wb_req typedef {rd, data}.
- One sub-module, wb_fifo: a parameterised synchronous FIFO exposing count and per-entry rd/valid vectors for the hazard compare.
- Arbitration, starve counter and output register stay in wb_arbiter.

Test Plan:
- ALU only: alu_valid=1, rd=3, data=0xDEAD_BEEF, 1 cycle -> next edge rf_wen=1, waddr=3, wdata=0xDEADBEEF; following cycle rf_wen=0.
- LSU only: push rd=7, data=0x1234 while ALU is idle -> rf_wen=1 with waddr=7 exactly 2 edges after the handshake; q_pending1 (q_addr1=7) is high from the edge after the handshake until the cycle after the write.
- Fill and backpressure, with alu_valid held at rd=1:
  - push 4 LSU results (rd 8..11) -> lsu_ready=0 after the 4th;
  - a 5th offer is held and not lost;
  - drop alu_valid -> rd 8,9,10,11 drain in order on consecutive cycles, then the 5th.
- Starvation: FIFO holds 1 entry, alu_valid=1 (rd=2) every cycle -> alu_stall=1 after 8 blocked cycles. Then with alu_valid=0 the entry pops, and alu_stall=0 the next cycle.
- x0 handling: ALU rd=0 with FIFO holding rd=5 -> rd 5 pops that cycle. LSU push with rd=0 -> lsu_ready handshake completes, count unchanged, no rf_wen. q_addr=0 -> q_pending=0 always.
- Reset mid-operation: FIFO holding 3 entries, rst=1 for 1 cycle -> rf_wen=0, lsu_ready=1, q_pending=0; no stale entry is written afterwards.
